// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins as forced-low, static-high or a shared 8-bit PWM.
// The PWM counter advances once every PRESCALE clocks. The duty value is captured
// only at the period wrap, so a period is never cut short or stretched.
module pwm_peripheral #(
  parameter int PRESCALE   = 13,
  parameter int PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] presc_cnt_r;
  logic [7:0]            pwm_cnt_r;
  logic [7:0]            duty_shadow_r;
  logic [15:0]           pins_r;
  logic                  period_start_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic                  pwm_level_s;
  logic [15:0]           en_out_s;
  logic [15:0]           en_pwm_s;
  logic [15:0]           pins_next_s;

  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Counter step strobe and end-of-period strobe.
  always_comb begin
    tick_s = (presc_cnt_r == PRESC_MAX);
    wrap_s = tick_s && (pwm_cnt_r == 8'hFF);
  end

  // Prescaler: counts 0..PRESCALE-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_r <= {PRESCALE_W{1'b0}};
    end else if (tick_s) begin
      presc_cnt_r <= {PRESCALE_W{1'b0}};
    end else begin
      presc_cnt_r <= presc_cnt_r + PRESC_ONE;
    end
  end

  // PWM counter: advances on each prescaler tick, wraps 255 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 8'h00;
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Duty shadow: sampled only at the period wrap so periods stay whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_r <= 8'h00;
    end else if (wrap_s) begin
      duty_shadow_r <= pwm_duty_cycle;
    end else begin
      duty_shadow_r <= duty_shadow_r;
    end
  end

  // PWM level: 0xFF is a true 100% duty, otherwise high while count < duty.
  always_comb begin
    pwm_level_s = 1'b0;
    if (duty_shadow_r == 8'hFF) begin
      pwm_level_s = 1'b1;
    end else begin
      pwm_level_s = (pwm_cnt_r < duty_shadow_r);
    end
  end

  // Per-pin selection: disabled pins are low, enabled pins are high or PWM.
  always_comb begin
    pins_next_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (!en_out_s[i]) begin
        pins_next_s[i] = 1'b0;
      end else if (en_pwm_s[i]) begin
        pins_next_s[i] = pwm_level_s;
      end else begin
        pins_next_s[i] = 1'b1;
      end
    end
  end

  // Output registers: pins and the period-start pulse (the cycle after wrap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pins_r         <= 16'h0000;
      period_start_r <= 1'b0;
    end else begin
      pins_r         <= pins_next_s;
      period_start_r <= wrap_s;
    end
  end

  assign uo_out       = pins_r[7:0];
  assign uio_out      = pins_r[15:8];
  assign period_start = period_start_r;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral with PRESCALE=2 (512-clk period).
// A timeline model predicts each cycle's outputs into a scoreboard queue;
// directed steps check period lengths, high times and reset behaviour.
module tb_pwm_peripheral;

  localparam int P   = 2;
  localparam int PER = 256 * P;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
    logic       ps;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic       period_start;

  exp_t       exp_q[$];
  int         vectors;
  int         miscompares;
  int         t;
  logic [7:0] m_shadow;

  pwm_peripheral #(.PRESCALE(P), .PRESCALE_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .uo_out          (uo_out),
    .uio_out         (uio_out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: predict from the model timeline, push, clock, pop and compare.
  task automatic step();
    exp_t        e;
    exp_t        g;
    int          cnt;
    logic        lvl;
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] pins;
    cnt  = (t / P) % 256;
    lvl  = (m_shadow == 8'hFF) ? 1'b1 : (cnt < int'(m_shadow));
    eo   = {en_reg_out_15_8, en_reg_out_7_0};
    ep   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    pins = 16'h0000;
    for (int i = 0; i < 16; i++) pins[i] = eo[i] & (ep[i] ? lvl : 1'b1);
    e.uo  = pins[7:0];
    e.uio = pins[15:8];
    e.ps  = ((t % PER) == PER - 1);
    if (e.ps) m_shadow = pwm_duty_cycle;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    t++;
    g = exp_q.pop_front();
    chk("uo_out", int'(uo_out), int'(g.uo));
    chk("uio_out", int'(uio_out), int'(g.uio));
    chk("period_start", int'(period_start), int'(g.ps));
  endtask

  // Step until period_start is seen; n = clocks taken, h = uo_out[0] highs.
  task automatic wait_ps(output int n, output int h);
    bit found;
    n = 0;
    h = 0;
    found = 1'b0;
    while (!found && n < PER + 50) begin
      step();
      n++;
      h += int'(uo_out[0]);
      if (period_start) found = 1'b1;
    end
    chk("ps_found", int'(found), 1);
  endtask

  // Count uo_out[0] high cycles over one full period, also report the first sample.
  task automatic count_period(output int h, output int first);
    h = 0;
    for (int k = 0; k < PER; k++) begin
      step();
      if (k == 0) first = int'(uo_out[0]);
      h += int'(uo_out[0]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_uo"}, int'(uo_out), 0);
    chk({tag, "_uio"}, int'(uio_out), 0);
    chk({tag, "_ps"}, int'(period_start), 0);
  endtask

  initial begin
    int n;
    int h;
    int first;
    vectors         = 0;
    miscompares     = 0;
    t               = 0;
    m_shadow        = 8'h00;
    rst_n           = 1'b0;
    en_reg_out_7_0  = 8'h00;
    en_reg_out_15_8 = 8'h00;
    en_reg_pwm_7_0  = 8'h00;
    en_reg_pwm_15_8 = 8'h00;
    pwm_duty_cycle  = 8'h00;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    rst_n = 1'b1;

    // All registers zero: pins stay low, period_start every PER clocks.
    wait_ps(n, h);
    chk("first_period_len", n, PER);
    wait_ps(n, h);
    chk("second_period_len", n, PER);

    // Static high on pins 0-7, pins 8-15 untouched.
    en_reg_out_7_0 = 8'hFF;
    step();
    chk("static_uo", int'(uo_out), 8'hFF);
    chk("static_uio", int'(uio_out), 0);
    repeat (5) step();

    // PWM on pin 0 at duty 0x80.
    en_reg_out_7_0 = 8'h01;
    en_reg_pwm_7_0 = 8'h01;
    pwm_duty_cycle = 8'h80;
    wait_ps(n, h);
    count_period(h, first);
    chk("rise_after_ps", first, 1);
    chk("duty80_high", h, 8'h80 * P);
    count_period(h, first);
    chk("duty80_high_2", h, 8'h80 * P);

    // Duty 0xFF: no low cycle, including across the wrap.
    pwm_duty_cycle = 8'hFF;
    wait_ps(n, h);
    count_period(h, first);
    chk("dutyFF_high", h, PER);
    count_period(h, first);
    chk("dutyFF_high_2", h, PER);

    // Duty 0x00: constantly low.
    pwm_duty_cycle = 8'h00;
    wait_ps(n, h);
    count_period(h, first);
    chk("duty00_high", h, 0);

    // Mid-period change 0x40 -> 0xC0 only affects the following period.
    pwm_duty_cycle = 8'h40;
    wait_ps(n, h);
    h = 0;
    for (int k = 0; k < PER; k++) begin
      if (k == 200) pwm_duty_cycle = 8'hC0;
      step();
      h += int'(uo_out[0]);
    end
    chk("duty40_keep", h, 8'h40 * P);
    count_period(h, first);
    chk("dutyC0_next", h, 8'hC0 * P);

    // Pin 9: PWM selected but disabled, then enabled mid-period.
    pwm_duty_cycle  = 8'h80;
    en_reg_out_15_8 = 8'h00;
    en_reg_pwm_15_8 = 8'h02;
    wait_ps(n, h);
    repeat (50) step();
    chk("pin9_disabled", int'(uio_out[1]), 0);
    en_reg_out_15_8 = 8'h02;
    step();
    chk("pin9_follows", int'(uio_out[1]), 1);

    // Asynchronous reset mid-period, held for 3 clocks.
    repeat (100) step();
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("rst_held");
    end
    rst_n    = 1'b1;
    t        = 0;
    m_shadow = 8'h00;
    exp_q.delete();
    wait_ps(n, h);
    chk("post_rst_period_len", n, PER);
    chk("post_rst_duty0", h, 0);
    count_period(h, first);
    chk("post_rst_duty80", h, 8'h80 * P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers written by the SPI register block and drives 16 output pins.
- Each pin is one of three things: forced low, static high, or a shared 8-bit PWM waveform.
- The PWM frequency comes from a prescaled free-running 8-bit counter.
- Duty-cycle changes take effect only at a period boundary, so no truncated or extra pulses are ever emitted.

Parameters:
- PRESCALE, 13, clk cycles per PWM counter step; PWM period = 256*PRESCALE clk cycles (≈3.0 kHz at 10 MHz). Legal range ≥1.
- PRESCALE_W, 8, width of the prescaler counter; must satisfy 2^PRESCALE_W ≥ PRESCALE.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_reg_out_7_0  input  8  output enable, pins 0-7 (uo_out)
- en_reg_out_15_8  input  8  output enable, pins 8-15 (uio_out)
- en_reg_pwm_7_0  input  8  PWM mode select, pins 0-7
- en_reg_pwm_15_8  input  8  PWM mode select, pins 8-15
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- uo_out  output  8  pins 0-7
- uio_out  output  8  pins 8-15
- period_start  output  1  one-cycle pulse on the first clk of each PWM period

Behaviour:
- Reset is asynchronous, active-low, on clk. During reset:
  - uo_out=0, uio_out=0, period_start=0
  - prescaler cnt=0, pwm_cnt=0, duty_shadow=0
- Prescaler:
  - presc_cnt counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted combinationally when presc_cnt==PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
- PWM counter:
  - pwm_cnt (8 bits) increments on tick and wraps 255→0.
  - wrap = tick && pwm_cnt==255.
- Duty shadow:
  - duty_shadow <= pwm_duty_cycle on wrap only.
  - Mid-period writes to pwm_duty_cycle have no effect until the next period.
  - The first period after reset uses duty 0.
- PWM level (combinational):
  - duty_shadow==0xFF → 1 (100% duty, no low glitch).
  - Otherwise → pwm_cnt < duty_shadow. High time = duty_shadow*PRESCALE clk cycles per period.
  - duty 0x00 → constantly 0.
- Per-pin output for bit i, with en_out/en_pwm being the concatenated 16-bit {15_8,7_0} registers. Registered, 1 clk latency from counter/input state:
  - en_out[i]=0 → 0, regardless of en_pwm[i].
  - en_out[i]=1, en_pwm[i]=0 → 1.
  - en_out[i]=1, en_pwm[i]=1 → pwm level.
- Enable registers are NOT shadowed: a change is visible on the pin 1 clk after the input changes.
- period_start is registered. It is high for exactly the one cycle in which pwm_cnt==0 and presc_cnt==0, i.e. the cycle after wrap.
- Simultaneous duty change and wrap: the value present on pwm_duty_cycle in the wrap cycle is captured.
- Reset mid-period: everything returns to reset values immediately. On release, counting restarts from 0 with duty_shadow=0.
- No other state; no handshakes with the SPI block. Inputs are already synchronous to clk.

Test Plan:
- Reset, all regs 0 → uo_out=uio_out=0 indefinitely; period_start pulses every 256*PRESCALE cycles.
- en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0x00 → uo_out=0xFF one clk later; uio_out stays 0x00.
- PRESCALE=2, en_out=0x0001, en_pwm=0x0001, duty=0x80:
  - From the second period on, pin0 is high exactly 256 clk, low 256 clk, per 512-clk period.
  - Rising edge occurs 1 clk after period_start.
- Duty=0xFF → pin0 constantly 1 with no low cycle across a wrap. Duty=0x00 → pin0 constantly 0.
- Change duty 0x40→0xC0 mid-period → the current period keeps high time 0x40*PRESCALE; the next period uses 0xC0*PRESCALE.
- en_out[9]=0, en_pwm[9]=1, duty=0x80 → uio_out[1]=0. Set en_out[9]=1 mid-period → uio_out[1] follows the PWM level from the next clk.
- Assert rst_n low mid-period for 3 clk → outputs 0 immediately (async); after release, first period_start occurs 256*PRESCALE clk later, duty effective 0 until then.
